// File: rtl/edram_multibank_ctrl.sv
// ---------------------------------------------------------------------------
// edram_multibank_ctrl
//
// Sequences a single access to one bank of a multi-bank embedded DRAM. A
// request is captured, the owning bank is woken through the PMU handshake,
// then the array is driven through precharge / decode / access. The last
// opened row is remembered so a same-row follow-up skips precharge.
//
// Ports
//   clk                 clock
//   rst                 asynchronous active-high reset
//   req_valid           request present
//   req_ready           request accepted this cycle (IDLE and not in reset)
//   req_addr            {bank, in-bank address}
//   req_we              1 = write, 0 = read
//   bank_active_status  per-bank powered indication from the PMU
//   request_wakeup      one-hot wake request to the PMU (WAIT_PMU only)
//   bank_sel            one-hot bank select (any non-IDLE state)
//   bank_addr           captured in-bank address (any non-IDLE state)
//   precharge_en        array precharge strobe
//   row_decode_en       row decoder enable
//   col_decode_en       column decoder enable
//   sense_amp_en        sense amplifier enable (read access)
//   write_driver_en     write driver enable (write access)
//   access_done         one-hot completion pulse (successful access only)
//   resp_valid          completion pulse
//   resp_err            wake-up timeout flag, qualified by resp_valid
// ---------------------------------------------------------------------------
module edram_multibank_ctrl #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_AW    = 11,
  parameter int ROW_AW     = 6,
  parameter int T_PRE      = 2,
  parameter int T_DEC      = 1,
  parameter int T_ACC      = 3,
  parameter int T_WAKE_MAX = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [$clog2(NUM_BANKS)+BANK_AW-1:0]  req_addr,
  input  logic                                  req_we,
  input  logic [NUM_BANKS-1:0]                  bank_active_status,
  output logic [NUM_BANKS-1:0]                  request_wakeup,
  output logic [NUM_BANKS-1:0]                  bank_sel,
  output logic [BANK_AW-1:0]                    bank_addr,
  output logic                                  precharge_en,
  output logic                                  row_decode_en,
  output logic                                  col_decode_en,
  output logic                                  sense_amp_en,
  output logic                                  write_driver_en,
  output logic [NUM_BANKS-1:0]                  access_done,
  output logic                                  resp_valid,
  output logic                                  resp_err
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int AW = BW + BANK_AW;

  // One shared timer serves the wake-up timeout and all timed array phases,
  // so it is sized for the longest of them.
  localparam int TMAX_A = (T_PRE > T_DEC) ? T_PRE : T_DEC;
  localparam int TMAX_B = (T_ACC > T_WAKE_MAX) ? T_ACC : T_WAKE_MAX;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] PRE_LAST  = TW'(T_PRE - 1);
  localparam logic [TW-1:0] DEC_LAST  = TW'(T_DEC - 1);
  localparam logic [TW-1:0] ACC_LAST  = TW'(T_ACC - 1);
  localparam logic [TW-1:0] WAKE_LAST = TW'(T_WAKE_MAX - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [NUM_BANKS-1:0] ONE_HOT_BASE = NUM_BANKS'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PMU,
    PRECHARGE,
    DECODE,
    ACCESS,
    FINISH
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [AW-1:0]      cap_addr;
  logic               cap_we;
  logic               err_flag;
  logic               err_next;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_next;
  logic               open_valid;
  logic [BW-1:0]      open_bank;
  logic [ROW_AW-1:0]  open_row;
  logic               load_open;
  logic               timeout;

  logic [BW-1:0]      cur_bank;
  logic [ROW_AW-1:0]  cur_row;
  logic [NUM_BANKS-1:0] cur_onehot;
  logic               bank_awake;
  logic               row_hit;
  logic               accept;

  assign cur_bank   = cap_addr[AW-1:BANK_AW];
  assign cur_row    = cap_addr[BANK_AW-1 -: ROW_AW];
  assign cur_onehot = ONE_HOT_BASE << cur_bank;
  assign bank_awake = bank_active_status[cur_bank];
  assign row_hit    = open_valid && (open_bank == cur_bank) && (open_row == cur_row);
  assign accept     = req_valid && (state == IDLE);

  // Ready is a pure function of state, gated by rst so it is low for the
  // whole reset window and not only after the first edge.
  assign req_ready = (state == IDLE) && !rst;

  // State, timer and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      err_flag <= err_next;
    end
  end

  // Request capture; address and direction are held for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr <= '0;
      cap_we   <= 1'b0;
    end else if (accept) begin
      cap_addr <= req_addr;
      cap_we   <= req_we;
    end
  end

  // Open-row tracking. A completed access loads the entry; a timeout or the
  // tracked bank losing power invalidates it. Loading takes priority so a
  // bank dropping in the same cycle its access retires still records it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_valid <= 1'b0;
      open_bank  <= '0;
      open_row   <= '0;
    end else if (load_open) begin
      open_valid <= 1'b1;
      open_bank  <= cur_bank;
      open_row   <= cur_row;
    end else if (timeout || !bank_active_status[open_bank]) begin
      open_valid <= 1'b0;
    end
  end

  // Next-state logic. The timer counts cycles spent in the current state and
  // is cleared on every transition so each timed phase starts from zero.
  always_comb begin
    state_next = state;
    timer_next = timer;
    err_next   = err_flag;
    load_open  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = WAIT_PMU;
          timer_next = '0;
          err_next   = 1'b0;
        end
      end
      WAIT_PMU: begin
        if (bank_awake) begin
          timer_next = '0;
          state_next = row_hit ? DECODE : PRECHARGE;
        end else if (timer == WAKE_LAST) begin
          timer_next = '0;
          timeout    = 1'b1;
          err_next   = 1'b1;
          state_next = FINISH;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      PRECHARGE: begin
        if (timer == PRE_LAST) begin
          timer_next = '0;
          state_next = DECODE;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      DECODE: begin
        if (timer == DEC_LAST) begin
          timer_next = '0;
          state_next = ACCESS;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      ACCESS: begin
        if (timer == ACC_LAST) begin
          timer_next = '0;
          load_open  = 1'b1;
          state_next = FINISH;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Output decode from registered state and captured request only, so an
  // asynchronous reset drops every strobe in the same instant.
  always_comb begin
    request_wakeup  = '0;
    bank_sel        = '0;
    bank_addr       = '0;
    precharge_en    = 1'b0;
    row_decode_en   = 1'b0;
    col_decode_en   = 1'b0;
    sense_amp_en    = 1'b0;
    write_driver_en = 1'b0;
    access_done     = '0;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;
    if (state != IDLE) begin
      bank_sel  = cur_onehot;
      bank_addr = cap_addr[BANK_AW-1:0];
    end
    case (state)
      WAIT_PMU:  request_wakeup = cur_onehot;
      PRECHARGE: precharge_en   = 1'b1;
      DECODE: begin
        row_decode_en = 1'b1;
        col_decode_en = 1'b1;
      end
      ACCESS: begin
        row_decode_en   = 1'b1;
        col_decode_en   = 1'b1;
        sense_amp_en    = !cap_we;
        write_driver_en = cap_we;
      end
      FINISH: begin
        resp_valid  = 1'b1;
        resp_err    = err_flag;
        access_done = err_flag ? '0 : cur_onehot;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_edram_multibank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_edram_multibank_ctrl
//
// Directed bench for edram_multibank_ctrl at default parameters. Each table
// record describes one request together with its hand-computed phase
// lengths; every output is checked in every cycle of the transaction.
// A hand-written sequence covers reset during an access.
// ---------------------------------------------------------------------------
module tb_edram_multibank_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic        req_we;
  logic [15:0] bank_active_status;
  logic [15:0] request_wakeup;
  logic [15:0] bank_sel;
  logic [10:0] bank_addr;
  logic        precharge_en;
  logic        row_decode_en;
  logic        col_decode_en;
  logic        sense_amp_en;
  logic        write_driver_en;
  logic [15:0] access_done;
  logic        resp_valid;
  logic        resp_err;

  int testsRun = 0;
  int failures = 0;

  edram_multibank_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_we             (req_we),
    .bank_active_status (bank_active_status),
    .request_wakeup     (request_wakeup),
    .bank_sel           (bank_sel),
    .bank_addr          (bank_addr),
    .precharge_en       (precharge_en),
    .row_decode_en      (row_decode_en),
    .col_decode_en      (col_decode_en),
    .sense_amp_en       (sense_amp_en),
    .write_driver_en    (write_driver_en),
    .access_done        (access_done),
    .resp_valid         (resp_valid),
    .resp_err           (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request. wakeAt: 0 = bank already powered, N = bank powers up
  // during the N-th WAIT_PMU cycle, -1 = never. drop: bank power is pulled
  // for two cycles before the request is issued.
  typedef struct {
    logic [3:0]  bank;
    logic [10:0] addr;
    logic        we;
    logic [15:0] base;
    int          wakeAt;
    logic        drop;
    int          expWait;
    int          expPre;
    logic        expErr;
    int          expFinish;
    logic [15:0] expDone;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic expReady,
                          input logic [15:0] expWake, input logic [15:0] expSel,
                          input logic [10:0] expAddr, input logic expPre,
                          input logic expDec, input logic expSense,
                          input logic expWd, input logic [15:0] expDone,
                          input logic expRv, input logic expRe);
    checkOutput({tag, " req_ready"},       32'(req_ready),       32'(expReady));
    checkOutput({tag, " request_wakeup"},  32'(request_wakeup),  32'(expWake));
    checkOutput({tag, " bank_sel"},        32'(bank_sel),        32'(expSel));
    checkOutput({tag, " bank_addr"},       32'(bank_addr),       32'(expAddr));
    checkOutput({tag, " precharge_en"},    32'(precharge_en),    32'(expPre));
    checkOutput({tag, " row_decode_en"},   32'(row_decode_en),   32'(expDec));
    checkOutput({tag, " col_decode_en"},   32'(col_decode_en),   32'(expDec));
    checkOutput({tag, " sense_amp_en"},    32'(sense_amp_en),    32'(expSense));
    checkOutput({tag, " write_driver_en"}, 32'(write_driver_en), 32'(expWd));
    checkOutput({tag, " access_done"},     32'(access_done),     32'(expDone));
    checkOutput({tag, " resp_valid"},      32'(resp_valid),      32'(expRv));
    checkOutput({tag, " resp_err"},        32'(resp_err),        32'(expRe));
  endtask

  task automatic checkQuiet(input string tag, input logic expReady);
    checkAll(tag, expReady, 16'h0, 16'h0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0,
             16'h0, 1'b0, 1'b0);
  endtask

  // Issues one table request and checks every output each cycle until the
  // cycle after FINISH. Phase codes: 0 IDLE, 1 WAIT, 2 PRE, 3 DEC, 4 ACC, 5 FIN.
  task automatic applyStimulus(input int idx);
    vec_t        v;
    logic [15:0] oh;
    int          ph;
    int          j;
    string       tag;
    v  = vecs[idx];
    oh = 16'h1 << v.bank;
    bank_active_status = v.base;
    if (v.drop) begin
      bank_active_status[v.bank] = 1'b0;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      bank_active_status = v.base;
    end
    req_addr  = {v.bank, v.addr};
    req_we    = v.we;
    req_valid = 1'b1;
    #1;
    checkOutput($sformatf("v%0d accept req_ready", idx), 32'(req_ready), 32'd1);
    for (int k = 1; k <= v.expFinish + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_valid = 1'b0;
      if (k <= v.expWait) begin
        ph = 1;
      end else begin
        j = k - v.expWait;
        if (v.expErr)                 ph = (j == 1) ? 5 : 0;
        else if (j <= v.expPre)       ph = 2;
        else if (j <= v.expPre + 1)   ph = 3;
        else if (j <= v.expPre + 4)   ph = 4;
        else if (j == v.expPre + 5)   ph = 5;
        else                          ph = 0;
      end
      tag = $sformatf("v%0d c%0d", idx, k);
      if (ph == 0) begin
        checkQuiet(tag, 1'b1);
      end else begin
        checkAll(tag, 1'b0,
                 (ph == 1) ? oh : 16'h0,
                 oh, v.addr,
                 ph == 2,
                 (ph == 3) || (ph == 4),
                 (ph == 4) && !v.we,
                 (ph == 4) && v.we,
                 (ph == 5) ? v.expDone : 16'h0,
                 ph == 5,
                 (ph == 5) && v.expErr);
      end
      if (k == v.wakeAt) bank_active_status[v.bank] = 1'b1;
    end
  endtask

  initial begin
    //           bank   addr     we    base      wake drop wait pre err fin done
    vecs[0]  = '{4'd3, 11'h155, 1'b0, 16'h0008,  0, 1'b0,  1, 2, 1'b0,  8, 16'h0008}; // miss read
    vecs[1]  = '{4'd3, 11'h155, 1'b1, 16'h0008,  0, 1'b0,  1, 0, 1'b0,  6, 16'h0008}; // row hit write
    vecs[2]  = '{4'd9, 11'h0AA, 1'b0, 16'h0008,  4, 1'b0,  4, 2, 1'b0, 11, 16'h0200}; // wake-up
    vecs[3]  = '{4'd5, 11'h0AA, 1'b0, 16'h0208, -1, 1'b0, 15, 0, 1'b1, 16, 16'h0000}; // timeout
    vecs[4]  = '{4'd9, 11'h0AA, 1'b1, 16'h0208,  0, 1'b0,  1, 2, 1'b0,  8, 16'h0200}; // miss after timeout
    vecs[5]  = '{4'd9, 11'h0AA, 1'b0, 16'h0208,  0, 1'b0,  1, 0, 1'b0,  6, 16'h0200}; // hit
    vecs[6]  = '{4'd3, 11'h555, 1'b0, 16'h0208,  0, 1'b0,  1, 2, 1'b0,  8, 16'h0008}; // other bank
    vecs[7]  = '{4'd3, 11'h155, 1'b0, 16'h0208,  0, 1'b0,  1, 2, 1'b0,  8, 16'h0008}; // same bank, other row
    vecs[8]  = '{4'd3, 11'h15F, 1'b1, 16'h0208,  0, 1'b0,  1, 0, 1'b0,  6, 16'h0008}; // same row, other column
    vecs[9]  = '{4'd3, 11'h155, 1'b0, 16'h0208,  0, 1'b1,  1, 2, 1'b0,  8, 16'h0008}; // power drop
    vecs[10] = '{4'd3, 11'h155, 1'b0, 16'h0208,  0, 1'b0,  1, 2, 1'b0,  8, 16'h0008}; // miss after reset

    rst                = 1'b1;
    req_valid          = 1'b0;
    req_addr           = '0;
    req_we             = 1'b0;
    bank_active_status = 16'h0000;

    #12;
    checkQuiet("reset", 1'b0);
    req_valid = 1'b1;
    #1;
    checkOutput("reset req_ready with valid", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkQuiet("post-reset idle", 1'b1);

    for (int i = 0; i < 10; i++) applyStimulus(i);

    // Reset during ACCESS: outputs must drop at once and no response appears.
    begin
      bit reached;
      reached = 1'b0;
      bank_active_status = 16'h0208;
      req_addr  = {4'd3, 11'h555};
      req_we    = 1'b0;
      req_valid = 1'b1;
      for (int k = 1; k <= 20 && !reached; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) req_valid = 1'b0;
        if (sense_amp_en === 1'b1) reached = 1'b1;
      end
      if (!reached) begin
        testsRun++;
        failures++;
        $display("[TB] FAIL reset_seq reach ACCESS: got no sense_amp_en, expected it within 20 cycles");
      end
      #2;
      rst = 1'b1;
      #1;
      checkQuiet("rst mid-access", 1'b0);
      repeat (2) begin
        @(posedge clk);
        #1;
        checkQuiet("rst held", 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkQuiet("rst released", 1'b1);
      repeat (8) begin
        @(posedge clk);
        #1;
        checkOutput("no resp after reset", 32'(resp_valid), 32'd0);
      end
    end

    applyStimulus(10);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
